// File: rtl/wash_control_panel.sv
// Front-panel controller for the Washing_Machine FSM: debounced buttons, frozen program
// selection, door interlock, bounded pause and a post-completion door hold.
module wash_control_panel #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PAUSE_MAX       = 20,
    parameter int unsigned DONE_HOLD       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start,
    input  logic btn_pause,
    input  logic sel_double,
    input  logic sel_dry,
    input  logic door_closed,
    input  logic wm_done,
    output logic start,
    output logic double_wash,
    output logic dry_wash,
    output logic time_pause,
    output logic door_lock,
    output logic busy,
    output logic door_alarm
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PC_W = $clog2(PAUSE_MAX + 1);
    localparam int unsigned HC_W = $clog2(DONE_HOLD + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PAUSE_MAX - 1);
    localparam logic [PC_W-1:0] PC_SAT  = PC_W'(PAUSE_MAX);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(DONE_HOLD - 1);
    localparam logic [HC_W-1:0] HC_SAT  = HC_W'(DONE_HOLD);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t          state;
    logic [1:0]      raw;
    logic [1:0]      level;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];
    logic [PC_W-1:0] pause_cnt;
    logic [HC_W-1:0] hold_cnt;
    logic            start_evt;
    logic            pause_evt;

    assign raw       = {btn_pause, btn_start};
    assign start_evt = press[0];
    assign pause_evt = press[1];

    // The counter tracks how long raw has disagreed with the accepted level; the flip
    // happens on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            press <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (raw[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= raw[i];
                    press[i]  <= raw[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start       <= 1'b0;
            double_wash <= 1'b0;
            dry_wash    <= 1'b0;
            time_pause  <= 1'b0;
            door_lock   <= 1'b0;
            busy        <= 1'b0;
            door_alarm  <= 1'b0;
            pause_cnt   <= '0;
            hold_cnt    <= '0;
        end else begin
            start      <= 1'b0;
            door_alarm <= 1'b0;
            case (state)
                IDLE: begin
                    double_wash <= sel_double & ~sel_dry;
                    dry_wash    <= sel_dry;
                    if (start_evt && door_closed) begin
                        state     <= LAUNCH;
                        start     <= 1'b1;
                        busy      <= 1'b1;
                        door_lock <= 1'b1;
                    end else if (start_evt) begin
                        door_alarm <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state <= RUN;
                end
                RUN: begin
                    if (wm_done) begin
                        state    <= DONE;
                        hold_cnt <= '0;
                    end else if (pause_evt) begin
                        state      <= PAUSE;
                        pause_cnt  <= '0;
                        time_pause <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (pause_cnt != PC_SAT) begin
                        pause_cnt <= pause_cnt + PC_W'(1);
                    end
                    if (wm_done) begin
                        state      <= DONE;
                        hold_cnt   <= '0;
                        time_pause <= 1'b0;
                    end else if (pause_evt || pause_cnt == PC_LAST) begin
                        state      <= RUN;
                        time_pause <= 1'b0;
                    end
                end
                DONE: begin
                    if (hold_cnt != HC_SAT) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                    if (hold_cnt == HC_LAST) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        door_lock <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_control_panel.sv
// Directed bench for wash_control_panel: press timing, debounce, interlock, program freeze,
// pause bound, completion hold and mid-cycle reset.
module tb_wash_control_panel;

    logic clk = 1'b0;
    logic rst;
    logic btn_start, btn_pause, sel_double, sel_dry, door_closed, wm_done;
    logic start, double_wash, dry_wash, time_pause, door_lock, busy, door_alarm;

    int tests    = 0;
    int failures = 0;

    wash_control_panel #(
        .DEBOUNCE_CYCLES(4),
        .PAUSE_MAX(20),
        .DONE_HOLD(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_start(btn_start),
        .btn_pause(btn_pause),
        .sel_double(sel_double),
        .sel_dry(sel_dry),
        .door_closed(door_closed),
        .wm_done(wm_done),
        .start(start),
        .double_wash(double_wash),
        .dry_wash(dry_wash),
        .time_pause(time_pause),
        .door_lock(door_lock),
        .busy(busy),
        .door_alarm(door_alarm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        btn_start   = 1'b0;
        btn_pause   = 1'b0;
        sel_double  = 1'b0;
        sel_dry     = 1'b0;
        door_closed = 1'b1;
        wm_done     = 1'b0;
        tick();
        tick();
        check("rst_start", start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_lock", door_lock, 1'b0);
        check("rst_pause", time_pause, 1'b0);
        check("rst_alarm", door_alarm, 1'b0);
        rst = 1'b0;
        tick();

        // Clean press held 10 cycles: event at cycle 4, start at cycle 5 only.
        btn_start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("t1_start_c%0d", i), start, (i == 5));
            check($sformatf("t1_busy_c%0d", i), busy, (i >= 5));
            check($sformatf("t1_lock_c%0d", i), door_lock, (i >= 5));
        end
        btn_start = 1'b0;

        // Completion: door stays locked 8 cycles after wm_done, then idle.
        wm_done = 1'b1;
        tick();
        wm_done = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check($sformatf("t6_lock_h%0d", j), door_lock, 1'b1);
            check($sformatf("t6_busy_h%0d", j), busy, 1'b1);
            tick();
        end
        check("t6_lock_released", door_lock, 1'b0);
        check("t6_idle_busy", busy, 1'b0);
        for (int j = 0; j < 6; j++) tick();

        // Bouncing start: 2 high / 1 low, five times, never accepted.
        for (int k = 0; k < 15; k++) begin
            btn_start = ((k % 3) != 2);
            tick();
            check($sformatf("t2_start_s%0d", k), start, 1'b0);
            check($sformatf("t2_busy_s%0d", k), busy, 1'b0);
        end
        btn_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("t2_busy_tail%0d", k), busy, 1'b0);
        end

        // Door open: press raises a one-cycle alarm and nothing else.
        door_closed = 1'b0;
        btn_start   = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("t3_alarm_c%0d", i), door_alarm, (i == 5));
            check($sformatf("t3_start_c%0d", i), start, 1'b0);
            check($sformatf("t3_busy_c%0d", i), busy, 1'b0);
        end
        btn_start   = 1'b0;
        door_closed = 1'b1;
        for (int k = 0; k < 6; k++) tick();

        // Program latch follows switches in IDLE with dry priority.
        sel_double = 1'b1;
        sel_dry    = 1'b0;
        tick();
        tick();
        check("t4_follow_double", double_wash, 1'b1);
        check("t4_follow_dry", dry_wash, 1'b0);
        sel_dry = 1'b1;
        tick();
        tick();
        check("t4_prio_double", double_wash, 1'b0);
        check("t4_prio_dry", dry_wash, 1'b1);
        btn_start = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        check("t4_start_pulse", start, 1'b1);
        btn_start = 1'b0;
        tick();
        check("t4_run_start_low", start, 1'b0);
        sel_dry    = 1'b0;
        sel_double = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("t4_frozen_double", double_wash, 1'b0);
        check("t4_frozen_dry", dry_wash, 1'b1);
        check("t4_run_busy", busy, 1'b1);
        for (int k = 0; k < 4; k++) tick();

        // Pause held without a second press: time_pause high exactly 20 cycles.
        btn_pause = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            tick();
            check($sformatf("t5a_pause_c%0d", i), time_pause, (i >= 5 && i <= 24));
            check($sformatf("t5a_lock_c%0d", i), door_lock, 1'b1);
        end
        btn_pause = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        // Pause then a second press after release: resumes early at cycle 16.
        btn_pause = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            btn_pause = (i < 5) || (i >= 11 && i <= 16);
            check($sformatf("t5b_pause_c%0d", i), time_pause, (i >= 5 && i <= 15));
            check($sformatf("t5b_busy_c%0d", i), busy, 1'b1);
        end
        btn_pause = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("t5b_still_run", busy, 1'b1);

        // Reset mid-run clears every output on the next edge.
        rst = 1'b1;
        tick();
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_lock", door_lock, 1'b0);
        check("t6_rst_pause", time_pause, 1'b0);
        check("t6_rst_start", start, 1'b0);
        check("t6_rst_dry", dry_wash, 1'b0);
        check("t6_rst_double", double_wash, 1'b0);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
